// File: rtl/spi_cfg_pkg.sv
// Shared constants, frame field positions and FSM encoding for the SPI
// configuration register bank.
package spi_cfg_pkg;

  localparam logic [6:0] MAX_ADDRESS = 7'h04;
  localparam int NUM_REGS = 5;

  localparam int ADDR_EN_OUT_LO = 'h00;
  localparam int ADDR_EN_OUT_HI = 'h01;
  localparam int ADDR_EN_PWM_LO = 'h02;
  localparam int ADDR_EN_PWM_HI = 'h03;
  localparam int ADDR_DUTY      = 'h04;

  localparam int FRAME_RW_BIT   = 15;
  localparam int FRAME_ADDR_MSB = 14;
  localparam int FRAME_ADDR_LSB = 8;
  localparam int FRAME_DATA_MSB = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } cfg_state_e;

  function automatic logic frame_is_write(input logic [15:0] frame);
    return frame[FRAME_RW_BIT];
  endfunction

endpackage

// File: rtl/spi_cfg_commit_ctrl_if.sv
// Frame handshake between the SPI shifter (master) and the register-bank controller (slave).
// A frame transfers on every clk edge where frame_valid && frame_ready; the master holds
// frame_valid and frame_data stable until that edge, and frame_ready never depends on frame_valid.
interface spi_cfg_commit_ctrl_if;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic        frame_ready;

  modport master (output frame_valid, output frame_data, input frame_ready);
  modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/cfg_commit_timer.sv
// Counts cycles spent with uncommitted shadow contents and pulses timeout to force a commit.
module cfg_commit_timer #(
  parameter int COMMIT_TIMEOUT = 1024,
  parameter int TMO_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dirty,
  input  logic commit,
  input  logic clear,
  output logic timeout
);

  localparam bit               ENABLED = (COMMIT_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] LAST    = TMO_W'(COMMIT_TIMEOUT - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!ENABLED || !dirty || commit || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The forced commit this pulse triggers is what clears the counter.
  assign timeout = ENABLED && dirty && (cnt == LAST);

endmodule

// File: rtl/spi_cfg_commit_ctrl.sv
// Validates SPI frames into shadow registers and commits them atomically to the
// active PWM configuration at a period boundary or after a timeout.
module spi_cfg_commit_ctrl
  import spi_cfg_pkg::*;
#(
  parameter logic [6:0] MAX_ADDR       = MAX_ADDRESS,
  parameter int         COMMIT_TIMEOUT = 1024,
  parameter int         TMO_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_cfg_commit_ctrl_if.slave  frame_if,
  input  logic                  pwm_period_end,
  output logic [7:0]            en_reg_out_7_0,
  output logic [7:0]            en_reg_out_15_8,
  output logic [7:0]            en_reg_pwm_7_0,
  output logic [7:0]            en_reg_pwm_15_8,
  output logic [7:0]            pwm_duty_cycle,
  output logic                  cfg_pending,
  output logic [7:0]            err_count,
  output cfg_state_e            state_dbg
);

  cfg_state_e  state, state_nxt;
  logic        handshake;
  logic [15:0] hold;
  logic [6:0]  hold_addr;
  logic [7:0]  shadow [NUM_REGS];
  logic [7:0]  active [NUM_REGS];
  logic        dirty;
  logic        wr_ok;
  logic        drop;
  logic        timeout;
  logic        commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    handshake = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_if.frame_valid) begin
          handshake = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign frame_if.frame_ready = (state == ST_IDLE);
  assign state_dbg            = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (handshake) begin
      hold <= frame_if.frame_data;
    end
  end

  assign hold_addr = hold[FRAME_ADDR_MSB:FRAME_ADDR_LSB];
  assign wr_ok     = (state == ST_CHECK) && frame_is_write(hold) && (hold_addr <= MAX_ADDR);
  assign drop      = (state == ST_CHECK) && !wr_ok;
  assign commit    = dirty && (pwm_period_end || timeout);

  cfg_commit_timer #(
    .COMMIT_TIMEOUT (COMMIT_TIMEOUT),
    .TMO_W          (TMO_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .dirty   (dirty),
    .commit  (commit),
    .clear   (1'b0),
    .timeout (timeout)
  );

  // Active loads the pre-write shadow; a same-cycle write keeps dirty set for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      dirty     <= 1'b0;
      err_count <= '0;
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (wr_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (hold_addr == 7'(i)) begin
            shadow[i] <= hold[FRAME_DATA_MSB:0];
          end
        end
      end
      if (wr_ok) begin
        dirty <= 1'b1;
      end else if (commit) begin
        dirty <= 1'b0;
      end
      if (drop && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign en_reg_out_7_0  = active[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = active[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = active[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = active[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = active[ADDR_DUTY];
  assign cfg_pending     = dirty;

endmodule

// File: tb/tb_spi_cfg_commit_ctrl.sv
// Bench for spi_cfg_commit_ctrl: two instances (timeout 8 and timeout disabled) driven in
// lockstep, checked every cycle against a frame-level reference model plus directed checks.
module tb_spi_cfg_commit_ctrl;
  import spi_cfg_pkg::*;

  localparam int TMO_A = 8;
  localparam int TMO_B = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fv = 1'b0;
  logic [15:0] fd = '0;
  logic        pe = 1'b0;

  always #5 clk = ~clk;

  spi_cfg_commit_ctrl_if if_a ();
  spi_cfg_commit_ctrl_if if_b ();
  assign if_a.frame_valid = fv;
  assign if_a.frame_data  = fd;
  assign if_b.frame_valid = fv;
  assign if_b.frame_data  = fd;

  logic [7:0] act [2][5];
  logic [7:0] err_o [2];
  logic       pend_o [2];
  logic       rdy [2];
  cfg_state_e st_o [2];
  assign rdy[0] = if_a.frame_ready;
  assign rdy[1] = if_b.frame_ready;

  spi_cfg_commit_ctrl #(.MAX_ADDR(7'h04), .COMMIT_TIMEOUT(TMO_A), .TMO_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_if(if_a), .pwm_period_end(pe),
    .en_reg_out_7_0(act[0][0]), .en_reg_out_15_8(act[0][1]), .en_reg_pwm_7_0(act[0][2]),
    .en_reg_pwm_15_8(act[0][3]), .pwm_duty_cycle(act[0][4]), .cfg_pending(pend_o[0]),
    .err_count(err_o[0]), .state_dbg(st_o[0])
  );

  spi_cfg_commit_ctrl #(.MAX_ADDR(7'h04), .COMMIT_TIMEOUT(TMO_B), .TMO_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_if(if_b), .pwm_period_end(pe),
    .en_reg_out_7_0(act[1][0]), .en_reg_out_15_8(act[1][1]), .en_reg_pwm_7_0(act[1][2]),
    .en_reg_pwm_15_8(act[1][3]), .pwm_duty_cycle(act[1][4]), .cfg_pending(pend_o[1]),
    .err_count(err_o[1]), .state_dbg(st_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: frames, pending window start cycle, and the commit rule.
  logic [7:0]  m_sh [2][5];
  logic [7:0]  m_ac [2][5];
  logic [7:0]  m_err [2];
  bit          m_dirty [2];
  bit          m_busy [2];
  logic [15:0] m_hold [2];
  int          m_since [2];
  int          m_cyc = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        m_sh[k][i] = '0;
        m_ac[k][i] = '0;
      end
      m_err[k] = '0;
      m_dirty[k] = 1'b0;
      m_busy[k] = 1'b0;
      m_hold[k] = '0;
      m_since[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int tmo);
    bit wr, commit, nd;
    int a;
    a = int'(m_hold[k][14:8]);
    wr = m_busy[k] && m_hold[k][15] && (a <= 4);
    commit = m_dirty[k] && (pe || (tmo != 0 && (m_cyc - m_since[k]) == tmo));
    if (commit) begin
      for (int i = 0; i < 5; i++) m_ac[k][i] = m_sh[k][i];
    end
    if (wr) m_sh[k][a] = m_hold[k][7:0];
    if (m_busy[k] && !wr && m_err[k] != 8'hFF) m_err[k] = m_err[k] + 8'd1;
    nd = wr || (m_dirty[k] && !commit);
    if (nd && (!m_dirty[k] || commit)) m_since[k] = m_cyc;
    m_dirty[k] = nd;
    if (m_busy[k]) begin
      m_busy[k] = 1'b0;
    end else if (fv) begin
      m_hold[k] = fd;
      m_busy[k] = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_cyc++;
      model_step(0, TMO_A);
      model_step(1, TMO_B);
    end
  end

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("d%0d.reg%0d", k, i), 16'(act[k][i]), 16'(m_ac[k][i]));
      end
      check($sformatf("d%0d.err", k), 16'(err_o[k]), 16'(m_err[k]));
      check($sformatf("d%0d.pending", k), 16'(pend_o[k]), 16'(m_dirty[k]));
      check($sformatf("d%0d.ready", k), 16'(rdy[k]), 16'(!m_busy[k]));
      check($sformatf("d%0d.state", k), 16'(st_o[k]), 16'(m_busy[k] ? ST_CHECK : ST_IDLE));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Returns right after the handshake edge; the frame is in its CHECK cycle.
  task automatic send(input logic [15:0] data);
    int guard = 0;
    while (!rdy[0] && guard < 4) begin
      step();
      guard++;
    end
    check("send.ready", 16'(rdy[0]), 16'h1);
    fv = 1'b1;
    fd = data;
    step();
    fv = 1'b0;
  endtask

  task automatic pulse_pe();
    pe = 1'b1;
    step();
    pe = 1'b0;
  endtask

  function automatic logic [15:0] rand_bad();
    if ($urandom_range(0, 1) == 1)
      return {1'b0, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))};
    return {1'b1, 7'($urandom_range(5, 127)), 8'($urandom_range(0, 255))};
  endfunction

  function automatic logic [15:0] rand_good();
    return {1'b1, 7'($urandom_range(0, 4)), 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] last_d;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) check("rst.reg", 16'(act[k][i]), 16'h0);
      check("rst.err", 16'(err_o[k]), 16'h0);
      check("rst.pending", 16'(pend_o[k]), 16'h0);
      check("rst.ready", 16'(rdy[k]), 16'h1);
    end
    rst_n = 1'b1;
    step();

    // Dropped read and out-of-range write, then saturation.
    send(16'h0455);
    send(16'h8533);
    step();
    for (int k = 0; k < 2; k++) begin
      check("t2.err2", 16'(err_o[k]), 16'h2);
      check("t2.pending", 16'(pend_o[k]), 16'h0);
      for (int i = 0; i < 5; i++) check("t2.reg", 16'(act[k][i]), 16'h0);
    end
    for (int n = 0; n < 300; n++) send(rand_bad());
    step();
    for (int k = 0; k < 2; k++) check("t2.err_sat", 16'(err_o[k]), 16'hFF);

    // Duty write held in shadow until a period end.
    send(16'h8410);
    step();
    for (int k = 0; k < 2; k++) begin
      check("t1.duty_hold", 16'(act[k][4]), 16'h00);
      check("t1.pending", 16'(pend_o[k]), 16'h1);
    end
    pulse_pe();
    for (int k = 0; k < 2; k++) begin
      check("t1.duty", 16'(act[k][4]), 16'h10);
      check("t1.clean", 16'(pend_o[k]), 16'h0);
    end

    // Last write wins; continuous valid gives one frame per two cycles.
    send(16'h80AA);
    send(16'h80BB);
    step();
    pulse_pe();
    for (int k = 0; k < 2; k++) check("t3.last_wins", 16'(act[k][0]), 16'hBB);
    last_d = '0;
    fv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3.ready_toggle", 16'(rdy[0]), 16'((i % 2) == 0));
      if (rdy[0]) begin
        last_d = 8'($urandom_range(0, 255));
        fd = {8'h81, last_d};
      end
      step();
    end
    fv = 1'b0;
    step();
    pulse_pe();
    for (int k = 0; k < 2; k++) check("t3.stream_last", 16'(act[k][1]), 16'(last_d));

    // Timeout commit exactly 8 cycles after dirty sets; disabled timeout never commits.
    send(16'h8201);
    step();
    check("t4.dirty", 16'(pend_o[0]), 16'h1);
    for (int c = 1; c < 8; c++) begin
      step();
      check("t4.early", 16'(act[0][2]), 16'h00);
    end
    step();
    check("t4.timeout_commit", 16'(act[0][2]), 16'h01);
    check("t4.timeout_clean", 16'(pend_o[0]), 16'h0);
    repeat (20) step();
    check("t4.no_tmo_reg", 16'(act[1][2]), 16'h00);
    check("t4.no_tmo_pend", 16'(pend_o[1]), 16'h1);
    pulse_pe();
    check("t4.no_tmo_pe", 16'(act[1][2]), 16'h01);

    // Period end during the CHECK cycle commits the pre-write shadow.
    send(16'h8001);
    send(16'h8377);
    pulse_pe();
    for (int k = 0; k < 2; k++) begin
      check("t5.old_value", 16'(act[k][3]), 16'h00);
      check("t5.prior_commit", 16'(act[k][0]), 16'h01);
      check("t5.still_pending", 16'(pend_o[k]), 16'h1);
    end
    pulse_pe();
    for (int k = 0; k < 2; k++) check("t5.committed", 16'(act[k][3]), 16'h77);

    // Asynchronous reset in the middle of a CHECK cycle.
    send(16'h8011);
    send(16'h8122);
    send(16'h8233);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) check("t6.async_reg", 16'(act[k][i]), 16'h0);
      check("t6.async_err", 16'(err_o[k]), 16'h0);
      check("t6.async_pend", 16'(pend_o[k]), 16'h0);
      check("t6.async_ready", 16'(rdy[k]), 16'h1);
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (12) step();
    for (int k = 0; k < 2; k++) begin
      check("t6.no_commit", 16'(act[k][1]), 16'h0);
      check("t6.idle_pend", 16'(pend_o[k]), 16'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if (rdy[0]) begin
        fv = ($urandom_range(0, 9) < 6);
        fd = ($urandom_range(0, 7) == 0) ? rand_bad() : rand_good();
      end
      pe = ($urandom_range(0, 9) == 0);
      step();
    end
    fv = 1'b0;
    pe = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cfg_commit_ctrl.md
Name: spi_cfg_commit_ctrl

Overview:
Register-bank controller between the SPI frame shifter and the output/PWM datapath. Accepts completed 16-bit SPI frames over a valid/ready handshake and validates the command and address. Accepted writes go to shadow registers. Shadow contents are committed atomically to the active configuration registers at a PWM period boundary, or on a timeout, so the PWM never sees a partial update.

Parameters:
MAX_ADDR, 7'h04, highest valid register address; frames addressed above it are dropped.
COMMIT_TIMEOUT, 1024, clk cycles of pending-but-uncommitted state before a forced commit; 0 disables the timeout.
TMO_W, 16, width of the timeout counter; COMMIT_TIMEOUT must fit in TMO_W bits.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
frame_valid  input  1  frame_data holds a complete SPI frame
frame_data  input  16  [15]=R/W (1=write), [14:8]=address, [7:0]=data
frame_ready  output  1  controller can accept a frame this cycle
pwm_period_end  input  1  one-cycle pulse from the PWM counter at period wrap
en_reg_out_7_0  output  8  active register, addr 0x00
en_reg_out_15_8  output  8  active register, addr 0x01
en_reg_pwm_7_0  output  8  active register, addr 0x02
en_reg_pwm_15_8  output  8  active register, addr 0x03
pwm_duty_cycle  output  8  active register, addr 0x04
cfg_pending  output  1  shadow differs from active (dirty flag)
err_count  output  8  count of dropped frames, saturates at 8'hFF

Behaviour:
- Reset (async, rst_n low):
  - All active and shadow registers, err_count, dirty flag and timeout counter clear to 0.
  - FSM goes to IDLE and any held frame is discarded.
  - frame_ready=1 from the first clk edge after reset release.
- FSM has two states, IDLE and CHECK. All outputs are registered except frame_ready, which is 1 exactly when state==IDLE.
- IDLE:
  - A handshake occurs when frame_valid && frame_ready.
  - On a handshake, latch frame_data into a hold register and go to CHECK.
  - frame_valid with frame_ready=0 is not a handshake; the shifter holds the frame.
- CHECK, one cycle, then always return to IDLE:
  - Write path: if hold[15]==1 and hold[14:8]<=MAX_ADDR, then shadow[addr] <= hold[7:0] and dirty <= 1.
  - Drop path (otherwise): err_count increments, saturating; shadow and dirty are unchanged. Reads (bit15=0) are dropped in this revision.
- Throughput: at most one frame per 2 cycles.
- Latency:
  - Handshake at edge N: shadow is updated at edge N+1.
  - The earliest commit is edge N+2, if pwm_period_end is high in the cycle before edge N+2.
- Commit: when dirty=1 and either pwm_period_end=1 or the timeout expires, all five active registers load shadow in the same edge and dirty clears.
- Commit with dirty=0 does nothing; active registers are unchanged.
- Commit and shadow write in the same cycle:
  - Active registers get the pre-write shadow.
  - The set of dirty wins, so dirty remains 1 and the new value is committed at the next boundary.
- Repeated writes to the same address before a commit: the last write wins.
- Timeout counter:
  - Clears while dirty=0.
  - Increments each cycle while dirty=1.
  - Forces a commit when it reaches COMMIT_TIMEOUT-1, then clears.
  - Also clears on any commit.
  - Inactive when COMMIT_TIMEOUT==0.
- cfg_pending equals dirty.

Decomposition:
- Package spi_cfg_pkg:
  - Constants: MAX_ADDRESS and register addresses ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_DUTY=0x04.
  - Frame field positions: RW bit 15, address [14:8], data [7:0].
  - FSM state encoding.
- One sub-module: cfg_commit_timer. It owns the timeout counter and its inputs are dirty, commit and clear. Its output is a one-cycle timeout pulse.

Test Plan:
1. Reset, then write frame 16'h8410 (addr 0x04, data 0x10) with no pwm_period_end -> pwm_duty_cycle stays 0x00 and cfg_pending=1. Pulse pwm_period_end -> next edge pwm_duty_cycle=0x10, cfg_pending=0.
2. Frames 16'h0455 (read) and 16'h8533 (addr 0x05) -> both dropped, err_count=2, cfg_pending=0, all active registers 0. Then 300 invalid frames -> err_count=0xFF.
3. Writes 16'h80AA then 16'h80BB, then a period end -> en_reg_out_7_0=0xBB. Hold frame_valid high continuously -> frame_ready toggles 1,0,1,0 and exactly one shadow write occurs per handshake.
4. COMMIT_TIMEOUT=8, write 16'h8201, no period end -> en_reg_pwm_7_0=0x01 exactly 8 cycles after dirty sets. COMMIT_TIMEOUT=0 -> never commits without pwm_period_end.
5. pwm_period_end coincides with the CHECK cycle of write 16'h8377 -> en_reg_pwm_15_8 keeps its old value and cfg_pending stays 1. Next pulse -> 0x77.
6. Assert rst_n low mid-CHECK after several uncommitted writes -> all outputs 0 immediately (asynchronous), no commit after release, frame_ready=1.
